// File: rtl/aib_pkg.sv
// Shared AIB rx framing definitions: sync pattern, field widths, aligner states, frame layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package aib_pkg;

    localparam int AIB_BEAT_W = 40;
    localparam int AIB_RAW_W  = 80;
    localparam int AIB_DATA_W = 72;
    localparam int AIB_SEQ_W  = 3;
    localparam int AIB_SYNC_W = 4;

    localparam logic [AIB_SYNC_W-1:0] AIB_SYNC_PATTERN = 4'b1010;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_e;

    // 80-bit frame: sync in the top nibble, then seq, valid flag and payload.
    typedef struct packed {
        logic [AIB_SYNC_W-1:0] sync;
        logic [AIB_SEQ_W-1:0]  seq;
        logic                  vld;
        logic [AIB_DATA_W-1:0] dat;
    } aib_frame_t;

endpackage

// File: rtl/aib_sync_fifo.sv
// Single-clock FIFO with full/empty flags and a head word visible combinationally.
// Latency: a write shows at the head after one edge; no write-to-read bypass.
// Backpressure: a write into a full FIFO is accepted only when a read happens on the same edge.
module aib_sync_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head is forced to zero while empty so the output is defined from reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written only when the push is accepted.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aib_rx_word_aligner.sv
// AIB rx word aligner: finds the 0/40-bit frame boundary, checks sync/seq, strips framing to 72-bit payload.
// Latency: frame captured at edge N shows on o_rx_valid after edge N+2 (raw reg -> aligned reg -> FIFO).
// Backpressure: valid/ready at the FIFO head; a frame arriving at a full FIFO is dropped and o_overflow sticks.
module aib_rx_word_aligner
    import aib_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic                  i_bus_clk,
    input  logic                  i_rst_n,
    input  logic                  c_bypass_word_align,
    input  logic [AIB_RAW_W-1:0]  i_raw_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic [AIB_DATA_W-1:0] o_rx_data,
    output logic                  o_locked,
    output logic                  o_align_offset,
    output logic                  o_overflow,
    output logic [7:0]            o_seq_err_cnt
);
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [AIB_RAW_W-1:0]  raw_q;
    logic [AIB_BEAT_W-1:0] prev_hi_q;
    aib_frame_t            cand0;
    aib_frame_t            cand1;
    aib_frame_t            sel;
    logic                  c0_sync;
    logic                  c1_sync;
    logic                  sel_sync;
    logic                  sel_good;
    align_state_e          state;
    logic [CNT_W-1:0]      good_cnt;
    logic [CNT_W-1:0]      bad_cnt;
    logic [AIB_SEQ_W-1:0]  exp_seq;
    logic                  wr_q;
    logic [AIB_DATA_W-1:0] wr_dat_q;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Raw stage: the current word plus the later beat of the previous word for the offset-40 candidate.
    always_ff @(posedge i_bus_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            raw_q     <= '0;
            prev_hi_q <= '0;
        end else begin
            raw_q     <= i_raw_data;
            prev_hi_q <= raw_q[AIB_RAW_W-1:AIB_BEAT_W];
        end
    end

    assign cand0    = raw_q;
    assign cand1    = {raw_q[AIB_BEAT_W-1:0], prev_hi_q};
    assign c0_sync  = (cand0.sync == AIB_SYNC_PATTERN);
    assign c1_sync  = (cand1.sync == AIB_SYNC_PATTERN);
    assign sel      = (c_bypass_word_align || !o_align_offset) ? cand0 : cand1;
    assign sel_sync = (sel.sync == AIB_SYNC_PATTERN);
    assign sel_good = sel_sync && (sel.seq == exp_seq);

    // Alignment FSM: SEARCH latches an offset, CONFIRM counts good frames, LOCKED tolerates short error bursts.
    always_ff @(posedge i_bus_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_SEARCH;
            good_cnt       <= '0;
            bad_cnt        <= '0;
            exp_seq        <= '0;
            o_align_offset <= 1'b0;
            o_locked       <= 1'b0;
            o_seq_err_cnt  <= '0;
        end else if (c_bypass_word_align) begin
            // Held in SEARCH so that leaving bypass restarts acquisition cleanly.
            state          <= ST_SEARCH;
            good_cnt       <= '0;
            bad_cnt        <= '0;
            o_align_offset <= 1'b0;
            o_locked       <= 1'b1;
        end else begin
            case (state)
                ST_SEARCH: begin
                    o_locked <= 1'b0;
                    if (c0_sync || c1_sync) begin
                        o_align_offset <= !c0_sync;
                        exp_seq        <= (c0_sync ? cand0.seq : cand1.seq) + 3'd1;
                        good_cnt       <= CNT_W'(1);
                        if (LOCK_CNT <= 1) begin
                            state    <= ST_LOCKED;
                            o_locked <= 1'b1;
                        end else begin
                            state <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (sel_good) begin
                        exp_seq <= exp_seq + 3'd1;
                        if (good_cnt == CNT_W'(LOCK_CNT - 1)) begin
                            state    <= ST_LOCKED;
                            o_locked <= 1'b1;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + CNT_W'(1);
                        end
                    end else begin
                        state    <= ST_SEARCH;
                        good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (sel_good) begin
                        bad_cnt <= '0;
                        exp_seq <= exp_seq + 3'd1;
                    end else begin
                        // A frame with valid sync but wrong seq resynchronises the expected seq.
                        exp_seq <= (sel_sync ? sel.seq : exp_seq) + 3'd1;
                        if (o_seq_err_cnt != 8'hFF) o_seq_err_cnt <= o_seq_err_cnt + 8'd1;
                        if (bad_cnt == CNT_W'(UNLOCK_CNT - 1)) begin
                            state    <= ST_SEARCH;
                            o_locked <= 1'b0;
                            bad_cnt  <= '0;
                            good_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_SEARCH;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

    // Aligned-frame stage: payload plus a write flag for frames that are allowed into the FIFO.
    always_ff @(posedge i_bus_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q     <= 1'b0;
            wr_dat_q <= '0;
        end else begin
            wr_q     <= c_bypass_word_align ? sel.vld : ((state == ST_LOCKED) && sel_good && sel.vld);
            wr_dat_q <= sel.dat;
        end
    end

    // Sticky overflow: a push that the FIFO cannot take because it is full with no read this edge.
    always_ff @(posedge i_bus_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (wr_q && fifo_full && !i_rx_ready) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_rx_valid = !fifo_empty;

    aib_sync_fifo #(
        .WIDTH (AIB_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_bus_clk),
        .rst_n   (i_rst_n),
        .wr_en   (wr_q),
        .wr_data (wr_dat_q),
        .rd_en   (i_rx_ready),
        .rd_data (o_rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
